// File: rtl/ysyx_23060240_pkg.sv
// Shared IFU types and constants.
// State encodings stay plain 3-bit constants for legacy tools.
package ysyx_23060240_pkg;

  typedef logic [2:0] ifu_state_e;

  localparam ifu_state_e IDLE      = 3'd0;
  localparam ifu_state_e REQ       = 3'd1;
  localparam ifu_state_e RSP       = 3'd2;
  localparam ifu_state_e RSP_DRAIN = 3'd3;
  localparam ifu_state_e OUT       = 3'd4;
  localparam ifu_state_e WAIT_NPC  = 3'd5;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic misaligned(
    input logic [31:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060240_ifu_if.sv
// Instruction memory fetch bus.
// Request channel carries an address; response returns word + error.
interface ysyx_23060240_ifu_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output imem_rsp_ready,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  imem_rsp_ready,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err
  );

endinterface

// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: one outstanding fetch, hands word + PC to IDU.
// Next PC arrives from write-back once per instruction.
module ysyx_23060240_ifu
  import ysyx_23060240_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  ysyx_23060240_ifu_if.master        imem,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic                       inst_err,
  input  logic                       npc_valid,
  input  logic [31:0]                npc,
  output logic                       npc_ready
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam bit          TO_EN   = TIMEOUT_CYC != 0;

  ifu_state_e  state;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_err_q;
  logic [31:0] tcnt;
  logic        drain;

  logic        rsp_v;
  logic        to_hit;
  logic        drain_clr;
  logic        drain_busy;
  logic        go;
  logic [31:0] go_pc;
  ifu_state_e  go_st;

  assign rsp_v      = imem.imem_rsp_valid;
  assign to_hit     = TO_EN && (tcnt == TO_LAST) && !rsp_v;
  assign drain_clr  = drain &&
                      (rsp_v || (state == RSP_DRAIN && to_hit));
  assign drain_busy = drain && !drain_clr;

  // A new fetch starts from IDLE, after npc, or once a drain ends.
  assign go = fetch_en &&
              ((state == IDLE) ||
               (state == WAIT_NPC && npc_valid) ||
               (state == RSP_DRAIN && drain_clr));

  assign go_pc = (state == WAIT_NPC) ? npc : pc;
  assign go_st = drain_busy          ? RSP_DRAIN :
                 misaligned(go_pc)   ? OUT       :
                                       REQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst_q     <= INST_NOP;
      inst_pc_q  <= RESET_PC;
      inst_err_q <= 1'b0;
      tcnt       <= '0;
      drain      <= 1'b0;
    end else begin
      if (drain_clr) drain <= 1'b0;
      unique case (state)
        REQ: begin
          if (imem.imem_req_ready) begin
            state <= RSP;
            tcnt  <= '0;
          end
        end
        RSP: begin
          if (rsp_v) begin
            state      <= OUT;
            inst_q     <= imem.imem_rsp_err ?
                          INST_NOP : imem.imem_rsp_data;
            inst_err_q <= imem.imem_rsp_err;
            inst_pc_q  <= pc;
          end else if (to_hit) begin
            state      <= OUT;
            inst_q     <= INST_NOP;
            inst_err_q <= 1'b1;
            inst_pc_q  <= pc;
            drain      <= 1'b1;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        RSP_DRAIN: begin
          if (drain_clr) state <= IDLE;
          else           tcnt  <= tcnt + 32'd1;
        end
        OUT: begin
          if (inst_ready) state <= WAIT_NPC;
        end
        WAIT_NPC: begin
          if (npc_valid) begin
            pc    <= npc;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (go) begin
        state <= go_st;
        pc    <= go_pc;
        tcnt  <= '0;
        if (go_st == OUT) begin
          inst_q     <= INST_NOP;
          inst_err_q <= 1'b1;
          inst_pc_q  <= go_pc;
        end
      end
    end
  end

  assign imem.imem_req_valid = state == REQ;
  assign imem.imem_req_addr  = pc;
  assign imem.imem_rsp_ready = (state == RSP) || drain;

  assign inst_valid = state == OUT;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_err   = inst_err_q;
  assign npc_ready  = state == WAIT_NPC;

  a_npc_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n)
    npc_valid |-> state == WAIT_NPC
  );

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Directed bench for the IFU with a scoreboard on both
// the fetch-request and the instruction-out handshakes.
module tb_ysyx_23060240_ifu;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        npc_valid;
  logic [31:0] npc;
  logic        npc_ready;

  ysyx_23060240_ifu_if bus ();

  ysyx_23060240_ifu #(
    .RESET_PC    (32'h8000_0000),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .imem       (bus),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_err   (inst_err),
    .npc_valid  (npc_valid),
    .npc        (npc),
    .npc_ready  (npc_ready)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, want);
    end
  endtask

  // Monitors: pop expectations on every handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (addr_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL req_unexp: got %08h want none",
                   bus.imem_req_addr);
        end else begin
          chk("req_addr", bus.imem_req_addr, addr_q.pop_front());
        end
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL inst_unexp: got %08h want none", inst);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("inst", inst, e.inst);
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_err", 32'(inst_err), 32'(e.err));
        end
      end
    end
  end

  task automatic push(
    input logic [31:0] i,
    input logic [31:0] p,
    input logic        e
  );
    exp_t x;
    x.inst = i;
    x.pc   = p;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic serve(
    input logic [31:0] a,
    input int          rdy_wait,
    input bit          drop,
    input logic [31:0] d,
    input logic        e
  );
    int n = 0;
    addr_q.push_back(a);
    while (!bus.imem_req_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.imem_req_valid) begin
      chk("req_wait", 32'(bus.imem_req_valid), 32'(1));
      return;
    end
    for (int i = 0; i < rdy_wait; i++) begin
      chk("req_hold_v", 32'(bus.imem_req_valid), 32'(1));
      chk("req_hold_a", bus.imem_req_addr, a);
      @(posedge clk); #1;
    end
    bus.imem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.imem_req_ready = 1'b0;
    if (drop) return;
    chk("rsp_ready", 32'(bus.imem_rsp_ready), 32'(1));
    chk("inst_early", 32'(inst_valid), 32'(0));
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = d;
    bus.imem_rsp_err   = e;
    @(posedge clk); #1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    chk("inst_lat", 32'(inst_valid), 32'(1));
  endtask

  task automatic take(
    input int          hold,
    input logic [31:0] nv,
    input bit          exp_req
  );
    int n = 0;
    while (!inst_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inst_valid) begin
      chk("inst_wait", 32'(inst_valid), 32'(1));
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk("inst_hold_v", 32'(inst_valid), 32'(1));
      if (exp_q.size() > 0) begin
        chk("inst_hold", inst, exp_q[0].inst);
        chk("inst_hold_pc", inst_pc, exp_q[0].pc);
      end
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    chk("npc_ready", 32'(npc_ready), 32'(1));
    npc_valid = 1'b1;
    npc       = nv;
    @(posedge clk); #1;
    npc_valid = 1'b0;
    chk("npc_req", 32'(bus.imem_req_valid), 32'(exp_req));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n              = 1'b1;
    fetch_en           = 1'b0;
    inst_ready         = 1'b0;
    npc_valid          = 1'b0;
    npc                = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_v", 32'(bus.imem_req_valid), 32'(0));
    chk("rst_rsp_r", 32'(bus.imem_rsp_ready), 32'(0));
    chk("rst_inst_v", 32'(inst_valid), 32'(0));
    chk("rst_npc_r", 32'(npc_ready), 32'(0));
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'h8000_0000);
    chk("rst_inst_err", 32'(inst_err), 32'(0));
    chk("rst_addr", bus.imem_req_addr, 32'h8000_0000);
    rst_n    = 1'b1;
    fetch_en = 1'b1;

    // basic fetch
    push(32'h0010_0073, 32'h8000_0000, 1'b0);
    serve(32'h8000_0000, 0, 1'b0, 32'h0010_0073, 1'b0);
    take(0, 32'h8000_0004, 1'b1);

    // back-pressure on both sides
    push(32'h0050_0093, 32'h8000_0004, 1'b0);
    serve(32'h8000_0004, 3, 1'b0, 32'h0050_0093, 1'b0);
    take(4, 32'h8000_0008, 1'b1);

    // bus error
    push(NOP, 32'h8000_0008, 1'b1);
    serve(32'h8000_0008, 0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    take(0, 32'h8000_0006, 1'b0);

    // misaligned npc
    push(NOP, 32'h8000_0006, 1'b1);
    chk("mis_out", 32'(inst_valid), 32'(1));
    take(0, 32'hFFFF_FFFC, 1'b1);

    // top of address space
    push(32'h0000_0517, 32'hFFFF_FFFC, 1'b0);
    serve(32'hFFFF_FFFC, 0, 1'b0, 32'h0000_0517, 1'b0);
    take(0, 32'h8000_0010, 1'b1);

    // timeout, then drained late response
    begin
      int n = 0;
      serve(32'h8000_0010, 0, 1'b1, '0, 1'b0);
      push(NOP, 32'h8000_0010, 1'b1);
      while (!inst_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("timeout_cyc", 32'(n), 32'(8));
    end
    take(0, 32'h8000_0014, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("drain_blk", 32'(bus.imem_req_valid), 32'(0));
      chk("drain_rdy", 32'(bus.imem_rsp_ready), 32'(1));
      @(posedge clk); #1;
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    chk("drain_req", 32'(bus.imem_req_valid), 32'(1));
    push(32'h0020_8133, 32'h8000_0014, 1'b0);
    serve(32'h8000_0014, 0, 1'b0, 32'h0020_8133, 1'b0);

    // fetch_en low parks in IDLE
    fetch_en = 1'b0;
    take(0, 32'h8000_0018, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("park", 32'(bus.imem_req_valid), 32'(0));
    end
    fetch_en = 1'b1;
    push(32'h0031_00B3, 32'h8000_0018, 1'b0);
    serve(32'h8000_0018, 0, 1'b0, 32'h0031_00B3, 1'b0);
    take(0, 32'h8000_001C, 1'b1);

    // reset while waiting for a response
    serve(32'h8000_001C, 0, 1'b1, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_req_v", 32'(bus.imem_req_valid), 32'(0));
    chk("mid_rsp_r", 32'(bus.imem_rsp_ready), 32'(0));
    chk("mid_inst_v", 32'(inst_valid), 32'(0));
    chk("mid_addr", bus.imem_req_addr, 32'h8000_0000);
    chk("mid_inst_pc", inst_pc, 32'h8000_0000);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1111_1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    push(32'h00A0_0093, 32'h8000_0000, 1'b0);
    serve(32'h8000_0000, 0, 1'b0, 32'h00A0_0093, 1'b0);
    take(0, 32'h8000_0004, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("exp_left", 32'(exp_q.size()), 32'(0));
    chk("addr_left", 32'(addr_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
